// File: rtl/serial_adder_if.sv
// ----------------------------------------------------------------------------
// serial_adder_if
//   Start/done handshake and operand/result bus for the bit-serial adder.
//
//   Signals:
//     start  requester -> adder   request, sampled only while the adder is idle
//     a, b   requester -> adder   WIDTH-bit operands, captured on accepted start
//     c_in   requester -> adder   carry-in, captured on accepted start
//     busy   adder -> requester   addition in progress
//     done   adder -> requester   one-cycle pulse when sum/c_out update
//     sum    adder -> requester   result (a + b + c_in) mod 2^WIDTH
//     c_out  adder -> requester   carry out of bit WIDTH-1
//     ovf    adder -> requester   signed overflow (only with SERIAL_ADDER_OVF_EN)
//
//   Modports: master = requester side, slave = adder side.
//   Build option: define SERIAL_ADDER_OVF_EN to add the ovf signal.
// ----------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, c_in,
                    input  busy, done, sum, c_out, ovf);
    modport slave  (input  start, a, b, c_in,
                    output busy, done, sum, c_out, ovf);
`else
    modport master (output start, a, b, c_in,
                    input  busy, done, sum, c_out);
    modport slave  (input  start, a, b, c_in,
                    output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: one full-adder cell plus a registered carry adds two
//   WIDTH-bit operands over WIDTH clock cycles, LSB first.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  serial_adder_if.slave (start/a/b/c_in in, busy/done/sum/c_out out)
//
//   Parameter: WIDTH (2..32), operand and result width.
//   Build option: define SERIAL_ADDER_OVF_EN to add the registered signed
//   overflow output bus.ovf.
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] ps_q;
    logic             cy_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    // The single full-adder cell and the next partial-sum value.
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] ps_d;

    always_comb begin
        fa_s  = a_sh_q[0] ^ b_sh_q[0] ^ cy_q;
        fa_co = (a_sh_q[0] & b_sh_q[0]) | (cy_q & (a_sh_q[0] ^ b_sh_q[0]));
        // New bit enters at the MSB; after WIDTH shifts bit i sits at i.
        ps_d  = {fa_s, ps_q[WIDTH-1:1]};
    end

    // Control, carry and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cy_q    <= bus.c_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    cy_q  <= fa_co;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= ps_d;
                        c_out_q <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // cy_q is the carry into the MSB on the final cycle.
                        ovf_q   <= cy_q ^ fa_co;
`endif
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the operand and partial-sum shift registers carry no reset; they
    // are fully reloaded or cleared on every accepted start, so reset would
    // only add logic without changing any visible output.
    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            if (bus.start) begin
                a_sh_q <= bus.a;
                b_sh_q <= bus.b;
                ps_q   <= '0;
            end
        end else begin
            a_sh_q <= a_sh_q >> 1;
            b_sh_q <= b_sh_q >> 1;
            ps_q   <= ps_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule
